// File: rtl/d_flip_flop_unit.sv
// Parameterised D-type register chain: STAGES cascaded WIDTH-bit registers
// with a synchronous active-low reset that loads RESET_VALUE into every stage.
module d_flip_flop_unit #(
  parameter int          WIDTH       = 1,
  parameter int          STAGES      = 1,
  parameter logic [63:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "d_flip_flop_unit: WIDTH must be in 1..64");
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $fatal(1, "d_flip_flop_unit: STAGES must be in 1..8");
  end

  // A wider reset value is deliberately cut down to the low WIDTH bits.
  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];

  always_comb begin
    s_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      s_d[i] = s_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (!rst_n) s_q[i] <= RST_V;
      else        s_q[i] <= s_d[i];
    end
  end

  assign q = s_q[STAGES-1];

endmodule

// File: tb/tb_d_flip_flop_unit.sv
// Randomised and directed bench for d_flip_flop_unit in three configurations,
// checked against an edge-history reference model.
module tb_d_flip_flop_unit;

  logic        clk;
  logic        ra, rb, rc;
  logic        da, qa;
  logic [7:0]  db, qb;
  logic [63:0] dc, qc;

  d_flip_flop_unit u_a (.clk(clk), .rst_n(ra), .d(da), .q(qa));

  d_flip_flop_unit #(.WIDTH(8), .STAGES(3), .RESET_VALUE(64'hA5))
    u_b (.clk(clk), .rst_n(rb), .d(db), .q(qb));

  d_flip_flop_unit #(.WIDTH(64), .STAGES(8), .RESET_VALUE(64'hFEED_0123_4567_89AB))
    u_c (.clk(clk), .rst_n(rc), .d(dc), .q(qc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: per unit, the rst_n and d values seen at every rising edge.
  int          stg  [3] = '{1, 3, 8};
  logic [63:0] rv   [3] = '{64'h0, 64'hA5, 64'hFEED_0123_4567_89AB};
  logic [63:0] mask [3] = '{64'h1, 64'hFF, '1};
  bit          rh   [3][$];
  logic [63:0] dh   [3][$];
  int          first_rst [3] = '{-1, -1, -1};

  // q after edge N: RESET_VALUE if any edge in the last STAGES edges was a
  // reset, otherwise d sampled STAGES-1 edges ago. Unknown before any reset.
  function automatic bit model(input int u, output logic [63:0] e);
    int n, k;
    e = '0;
    if (first_rst[u] < 0) return 1'b0;
    n = rh[u].size() - 1;
    k = n - stg[u] + 1;
    for (int j = (k < 0 ? 0 : k); j <= n; j++) begin
      if (!rh[u][j]) begin
        e = rv[u] & mask[u];
        return 1'b1;
      end
    end
    e = dh[u][k] & mask[u];
    return 1'b1;
  endfunction

  logic [63:0] last_q [3];
  bit          have_last = 1'b0;

  task automatic record(input int u, input bit r, input logic [63:0] dv);
    if (!r && first_rst[u] < 0) first_rst[u] = rh[u].size();
    rh[u].push_back(r);
    dh[u].push_back(dv);
  endtask

  task automatic cycle(input bit a_r, input logic a_d,
                       input bit b_r, input logic [7:0] b_d,
                       input bit c_r, input logic [63:0] c_d,
                       input bit glitch);
    logic [63:0] e;
    @(negedge clk);
    if (have_last) begin
      chk("hold_a", {63'b0, qa}, last_q[0]);
      chk("hold_b", {56'b0, qb}, last_q[1]);
      chk("hold_c", qc, last_q[2]);
    end
    da = a_d; db = b_d; dc = c_d;
    if (glitch) begin
      ra = 1'b0; rb = 1'b0; rc = 1'b0;
      #1;
    end
    ra = a_r; rb = b_r; rc = c_r;
    #1;
    if (have_last) begin
      chk("mid_a", {63'b0, qa}, last_q[0]);
      chk("mid_b", {56'b0, qb}, last_q[1]);
      chk("mid_c", qc, last_q[2]);
    end
    @(posedge clk);
    record(0, a_r, {63'b0, a_d});
    record(1, b_r, {56'b0, b_d});
    record(2, c_r, c_d);
    #1;
    if (model(0, e)) chk("q_a", {63'b0, qa}, e);
    if (model(1, e)) chk("q_b", {56'b0, qb}, e);
    if (model(2, e)) chk("q_c", qc, e);
    last_q[0] = {63'b0, qa};
    last_q[1] = {56'b0, qb};
    last_q[2] = qc;
    have_last = 1'b1;
  endtask

  initial begin
    ra = 1'b0; rb = 1'b0; rc = 1'b0;
    da = 1'b0; db = '0; dc = '0;

    // reset for two edges
    cycle(0, 1'b0, 0, 8'h00, 0, 64'h0, 0);
    chk("rst_a", {63'b0, qa}, 64'h0);
    chk("rst_b", {56'b0, qb}, 64'hA5);
    cycle(0, 1'b1, 0, 8'h77, 0, 64'h1234, 0);

    // data follow on the single stage, multi-stage latency on unit b
    cycle(1, 1'b0, 1, 8'h01, 1, 64'h11, 0);
    chk("lat_b0", {56'b0, qb}, 64'hA5);
    cycle(1, 1'b1, 1, 8'h02, 1, 64'h22, 0);
    chk("lat_b1", {56'b0, qb}, 64'hA5);
    cycle(1, 1'b0, 1, 8'h03, 1, 64'h33, 0);
    chk("lat_b2", {56'b0, qb}, 64'h01);
    cycle(1, 1'b1, 1, 8'h04, 1, 64'h44, 0);
    chk("lat_b3", {56'b0, qb}, 64'h02);

    // reset priority: d=1 with reset low, then release
    cycle(0, 1'b1, 1, 8'h05, 1, 64'h55, 0);
    chk("prio_a", {63'b0, qa}, 64'h0);
    cycle(1, 1'b1, 1, 8'h06, 1, 64'h66, 0);
    chk("prio_rel_a", {63'b0, qa}, 64'h1);

    // mid-stream reset on an incrementing stream
    for (int i = 0; i < 6; i++)
      cycle(1, i[0], 1, 8'(8'h10 + i), 1, 64'(i), 0);
    cycle(0, 1'b1, 0, 8'h20, 0, 64'h99, 0);
    for (int i = 0; i < 10; i++)
      cycle(1, i[0], 1, 8'(8'h30 + i), 1, 64'(100 + i), 0);

    // reset glitches strictly between edges
    for (int i = 0; i < 4; i++)
      cycle(1, ~i[0], 1, 8'(8'h40 + i), 1, 64'(200 + i), 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 15) != 0), 1'($urandom),
            ($urandom_range(0, 15) != 0), 8'($urandom),
            ($urandom_range(0, 23) != 0), {$urandom, $urandom},
            ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
